// File: rtl/ntt_bram_sched_pkg.sv
// Shared constants, FSM encoding and address helper for the NTT BRAM scheduler.
package ntt_bram_sched_pkg;

  localparam int NTT_N      = 256;
  localparam int NTT_Q      = 3329;
  localparam int NTT_LAYERS = 7;
  localparam int NTT_ZETA_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when j is the final index of its butterfly group (offset == len-1).
  function automatic logic last_in_group(input logic [7:0] j, input logic [7:0] len);
    return (j & (len - 8'd1)) == (len - 8'd1);
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Reset-clearable shift register used to align write-back and twiddle data with the BRAM pipeline.
module ntt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift one stage per clock; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/ntt_bram_sched.sv
// Sequences one 256-point NTT/INTT over a dual-port BRAM: one butterfly pair per cycle,
// zeta index aligned with read data, in-place write-back after BF_LAT cycles.
module ntt_bram_sched
  import ntt_bram_sched_pkg::*;
#(
  parameter int N          = NTT_N,
  parameter int ADDR_WIDTH = 8,
  parameter int BF_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  inverse,
  output logic                  busy,
  output logic                  done,
  output logic                  en_a,
  output logic                  en_b,
  output logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [ADDR_WIDTH-1:0] raddr_b,
  output logic                  we_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] waddr_a,
  output logic [ADDR_WIDTH-1:0] waddr_b,
  output logic                  bf_valid,
  output logic [NTT_ZETA_W-1:0] zeta_idx
);

  localparam logic [ADDR_WIDTH-1:0] LEN_MAX   = ADDR_WIDTH'(N / 2);
  localparam logic [ADDR_WIDTH-1:0] LEN_MIN   = ADDR_WIDTH'(2);
  localparam logic [6:0]            CNT_LAST  = 7'(N / 2 - 1);
  localparam logic [3:0]            DRN_LAST  = 4'(BF_LAT);
  localparam int                    WB_W      = 1 + 2 * ADDR_WIDTH;

  state_t                  state_r, state_s;
  logic                    inv_r, inv_s;
  logic [ADDR_WIDTH-1:0]   len_r, len_s;
  logic [ADDR_WIDTH-1:0]   j_r, j_s;
  logic [ADDR_WIDTH-1:0]   rb_r, rb_s;
  logic [NTT_ZETA_W-1:0]   k_r, k_s;
  logic [6:0]              cnt_r, cnt_s;
  logic [3:0]              drn_r, drn_s;
  logic                    issue_r, issue_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic [ADDR_WIDTH-1:0]   nlen_s;
  logic [ADDR_WIDTH-1:0]   jn_s;

  // State and sequencing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      inv_r   <= 1'b0;
      len_r   <= '0;
      j_r     <= '0;
      rb_r    <= '0;
      k_r     <= '0;
      cnt_r   <= 7'd0;
      drn_r   <= 4'd0;
      issue_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      inv_r   <= inv_s;
      len_r   <= len_s;
      j_r     <= j_s;
      rb_r    <= rb_s;
      k_r     <= k_s;
      cnt_r   <= cnt_s;
      drn_r   <= drn_s;
      issue_r <= issue_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state and next-issue computation.
  always_comb begin
    state_s = state_r;
    inv_s   = inv_r;
    len_s   = len_r;
    j_s     = j_r;
    rb_s    = rb_r;
    k_s     = k_r;
    cnt_s   = cnt_r;
    drn_s   = drn_r;
    issue_s = 1'b0;
    busy_s  = busy_r;
    done_s  = 1'b0;
    nlen_s  = inv_r ? (len_r << 1) : (len_r >> 1);
    jn_s    = j_r + 8'd1;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
          inv_s   = inverse;
          len_s   = inverse ? LEN_MIN : LEN_MAX;
          k_s     = inverse ? 7'd127 : 7'd1;
          j_s     = '0;
          rb_s    = inverse ? LEN_MIN : LEN_MAX;
          cnt_s   = 7'd0;
          issue_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // k advances once per group and keeps running across layers.
        if (last_in_group(j_r, len_r)) begin
          k_s  = inv_r ? (k_r - 7'd1) : (k_r + 7'd1);
          jn_s = j_r + len_r + 8'd1;
        end else begin
          jn_s = j_r + 8'd1;
        end
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DRAIN;
          drn_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r + 7'd1;
          j_s     = jn_s;
          rb_s    = jn_s + len_r;
          issue_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drn_r == DRN_LAST) begin
          if (inv_r ? (len_r == LEN_MAX) : (len_r == LEN_MIN)) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            state_s = ST_RUN;
            len_s   = nlen_s;
            j_s     = '0;
            rb_s    = nlen_s;
            cnt_s   = 7'd0;
            issue_s = 1'b1;
          end
        end else begin
          drn_s = drn_r + 4'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  logic [WB_W-1:0]         wb_d_s, wb_q_s;
  logic [NTT_ZETA_W:0]     bf_d_s, bf_q_s;

  assign wb_d_s = issue_r ? {1'b1, j_r, rb_r} : '0;
  assign bf_d_s = issue_r ? {1'b1, k_r} : '0;

  ntt_delay_line #(.WIDTH(WB_W), .DEPTH(BF_LAT + 1)) u_wb_dly (
    .clk (clk),
    .rst (rst),
    .d   (wb_d_s),
    .q   (wb_q_s)
  );

  ntt_delay_line #(.WIDTH(NTT_ZETA_W + 1), .DEPTH(1)) u_bf_dly (
    .clk (clk),
    .rst (rst),
    .d   (bf_d_s),
    .q   (bf_q_s)
  );

  assign busy     = busy_r;
  assign done     = done_r;
  assign raddr_a  = j_r;
  assign raddr_b  = rb_r;
  assign we_a     = wb_q_s[WB_W-1];
  assign we_b     = wb_q_s[WB_W-1];
  assign waddr_a  = wb_q_s[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign waddr_b  = wb_q_s[ADDR_WIDTH-1:0];
  assign en_a     = issue_r | wb_q_s[WB_W-1];
  assign en_b     = issue_r | wb_q_s[WB_W-1];
  assign bf_valid = bf_q_s[NTT_ZETA_W];
  assign zeta_idx = bf_q_s[NTT_ZETA_W-1:0];

endmodule

// File: tb/tb_ntt_bram_sched.sv
// Randomized self-checking bench: per-cycle comparison against a loop-level NTT schedule model.
module tb_ntt_bram_sched;

  localparam int BF_LAT   = 2;
  localparam int PERIOD   = 129 + BF_LAT;
  localparam int DONE_CYC = 1 + 7 * PERIOD;
  localparam int LAST_CYC = DONE_CYC + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       inverse = 1'b0;
  logic       busy, done, en_a, en_b, we_a, we_b, bf_valid;
  logic [7:0] raddr_a, raddr_b, waddr_a, waddr_b;
  logic [6:0] zeta_idx;

  ntt_bram_sched #(.N(256), .ADDR_WIDTH(8), .BF_LAT(BF_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inverse  (inverse),
    .busy     (busy),
    .done     (done),
    .en_a     (en_a),
    .en_b     (en_b),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .we_a     (we_a),
    .we_b     (we_b),
    .waddr_a  (waddr_a),
    .waddr_b  (waddr_b),
    .bf_valid (bf_valid),
    .zeta_idx (zeta_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit m_iss [LAST_CYC+1];
  bit m_bfv [LAST_CYC+1];
  bit m_we  [LAST_CYC+1];
  int m_ra  [LAST_CYC+1];
  int m_rb  [LAST_CYC+1];
  int m_wa  [LAST_CYC+1];
  int m_wb  [LAST_CYC+1];
  int m_z   [LAST_CYC+1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, want %h", tag, cyc, obs, exp);
    end
  endtask

  // Reference schedule: nested layer/group/butterfly loops, timed from the start sample.
  task automatic build_model(input bit inv);
    int k;
    for (int c = 0; c <= LAST_CYC; c++) begin
      m_iss[c] = 0; m_bfv[c] = 0; m_we[c] = 0;
      m_ra[c] = 0; m_rb[c] = 0; m_wa[c] = 0; m_wb[c] = 0; m_z[c] = 0;
    end
    k = inv ? 127 : 1;
    for (int l = 0; l < 7; l++) begin
      int len = inv ? (2 << l) : (128 >> l);
      int idx = 0;
      for (int g = 0; g < 256; g += 2 * len) begin
        for (int j = g; j < g + len; j++) begin
          int c = 1 + l * PERIOD + idx;
          m_iss[c] = 1; m_ra[c] = j; m_rb[c] = j + len;
          m_bfv[c+1] = 1; m_z[c+1] = k;
          m_we[c+1+BF_LAT] = 1; m_wa[c+1+BF_LAT] = j; m_wb[c+1+BF_LAT] = j + len;
          idx++;
        end
        k = inv ? k - 1 : k + 1;
      end
    end
  endtask

  function automatic logic [63:0] exp_vec(input int c);
    logic b, d, en;
    b  = (c >= 1) && (c < DONE_CYC);
    d  = (c == DONE_CYC);
    en = m_iss[c] | m_we[c];
    return {18'd0, b, d, en, en, m_we[c], m_we[c], m_bfv[c],
            8'(m_ra[c]), 8'(m_rb[c]), 8'(m_wa[c]), 8'(m_wb[c]), 7'(m_z[c])};
  endfunction

  function automatic logic [63:0] obs_vec(input int c);
    logic [7:0] ra, rb, wa, wb;
    logic [6:0] z;
    ra = m_iss[c] ? raddr_a : 8'd0;
    rb = m_iss[c] ? raddr_b : 8'd0;
    wa = m_we[c]  ? waddr_a : 8'd0;
    wb = m_we[c]  ? waddr_b : 8'd0;
    z  = m_bfv[c] ? zeta_idx : 7'd0;
    return {18'd0, busy, done, en_a, en_b, we_a, we_b, bf_valid, ra, rb, wa, wb, z};
  endfunction

  function automatic logic [63:0] all_outs();
    return {18'd0, busy, done, en_a, en_b, we_a, we_b, bf_valid,
            raddr_a, raddr_b, waddr_a, waddr_b, zeta_idx};
  endfunction

  task automatic run_op(input int op, input bit inv, input int rst_at);
    int we_cnt = 0;
    string tag;
    build_model(inv);
    tag = $sformatf("op%0d_%s", op, inv ? "inv" : "fwd");
    @(negedge clk);
    start = 1'b1; inverse = inv; cyc = 0;
    for (int c = 1; c <= LAST_CYC; c++) begin
      @(negedge clk);
      cyc = c;
      chk(tag, obs_vec(c), exp_vec(c));
      if (we_a) we_cnt++;
      if (c == rst_at) begin
        #1 rst = 1'b1;
        #1 chk("rst_outs", all_outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        for (int p = 0; p < BF_LAT + 6; p++) begin
          @(negedge clk);
          cyc = c + 3 + p;
          chk("post_rst", {57'd0, busy, done, en_a, en_b, we_a, we_b, bf_valid}, 64'd0);
        end
        return;
      end
      // Re-pulsed start and a wandering inverse while busy must be ignored.
      if (c >= 2 && c <= 900) begin
        start   = (c == 300) || ($urandom_range(0, 15) == 0);
        inverse = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, "_we_cnt"}, 64'(we_cnt), 64'd896);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cyc = 0;
    chk("reset_state", all_outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_state", all_outs(), 64'd0);
    run_op(0, 1'b0, -1);
    run_op(1, 1'b1, -1);
    run_op(2, 1'b1, 500);
    run_op(3, 1'b0, -1);
    run_op(4, 1'($urandom_range(0, 1)), 100 + $urandom_range(0, 700));
    run_op(5, 1'($urandom_range(0, 1)), -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
